// File: rtl/ex_mem_pipe.sv
// rtl/ex_mem_pipe.sv - EX/MEM pipeline register with precise arithmetic-overflow trap
module ex_mem_pipe #(
  parameter logic [4:0] OVF_CAUSE = 5'd12,
  parameter int         CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             ex_valid,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_alu_result,
  input  logic             ex_alu_overflow,
  input  logic             ex_reg_write,
  input  logic [4:0]       ex_reg_write_addr,
  input  logic             ex_mem_read,
  input  logic             ex_mem_write,
  input  logic [31:0]      ex_mem_write_data,
  input  logic             exc_ack,
  output logic             mem_valid,
  output logic [31:0]      mem_pc,
  output logic [31:0]      mem_alu_result,
  output logic             mem_reg_write,
  output logic [4:0]       mem_reg_write_addr,
  output logic             mem_mem_read,
  output logic             mem_mem_write,
  output logic [31:0]      mem_mem_write_data,
  output logic             exc_pending,
  output logic [31:0]      exc_epc,
  output logic [4:0]       exc_cause,
  output logic [CNT_W-1:0] ovf_count
);

  typedef enum logic {RUN = 1'b0, TRAP_WAIT = 1'b1} state_t;

  state_t             state_q, state_d;
  logic               valid_q, valid_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        result_q, result_d;
  logic               reg_write_q, reg_write_d;
  logic [4:0]         addr_q, addr_d;
  logic               mem_read_q, mem_read_d;
  logic               mem_write_q, mem_write_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        epc_q, epc_d;
  logic [4:0]         cause_q, cause_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               trap_take;

  // Overflow is only sampled when the slot actually advances in RUN.
  assign trap_take = (state_q == RUN) && !flush && !stall && ex_valid && ex_alu_overflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:       if (trap_take) state_d = TRAP_WAIT;
      TRAP_WAIT: if (exc_ack)   state_d = RUN;
      default:   state_d = RUN;
    endcase
  end

  always_comb begin
    valid_d     = valid_q;
    pc_d        = pc_q;
    result_d    = result_q;
    reg_write_d = reg_write_q;
    addr_d      = addr_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    wdata_d     = wdata_q;
    epc_d       = epc_q;
    cause_d     = cause_q;
    cnt_d       = cnt_q;
    if (state_q == TRAP_WAIT || flush || trap_take) begin
      valid_d     = 1'b0;
      pc_d        = '0;
      result_d    = '0;
      reg_write_d = 1'b0;
      addr_d      = '0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      wdata_d     = '0;
    end else if (!stall) begin
      valid_d     = ex_valid;
      pc_d        = ex_pc;
      result_d    = ex_alu_result;
      reg_write_d = ex_valid && ex_reg_write;
      addr_d      = ex_reg_write_addr;
      mem_read_d  = ex_valid && ex_mem_read;
      mem_write_d = ex_valid && ex_mem_write;
      wdata_d     = ex_mem_write_data;
    end
    if (trap_take) begin
      epc_d   = ex_pc;
      cause_d = OVF_CAUSE;
      if (!(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      result_q    <= '0;
      reg_write_q <= 1'b0;
      addr_q      <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      wdata_q     <= '0;
      epc_q       <= '0;
      cause_q     <= '0;
      cnt_q       <= '0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      result_q    <= result_d;
      reg_write_q <= reg_write_d;
      addr_q      <= addr_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      wdata_q     <= wdata_d;
      epc_q       <= epc_d;
      cause_q     <= cause_d;
      cnt_q       <= cnt_d;
    end
  end

  assign mem_valid          = valid_q;
  assign mem_pc             = pc_q;
  assign mem_alu_result     = result_q;
  assign mem_reg_write      = reg_write_q;
  assign mem_reg_write_addr = addr_q;
  assign mem_mem_read       = mem_read_q;
  assign mem_mem_write      = mem_write_q;
  assign mem_mem_write_data = wdata_q;
  assign exc_pending        = (state_q == TRAP_WAIT);
  assign exc_epc            = epc_q;
  assign exc_cause          = cause_q;
  assign ovf_count          = cnt_q;

endmodule

// File: doc/ex_mem_pipe.md
# ex_mem_pipe

EX/MEM pipeline register for the pipelined MIPS CPU, directly downstream of the ALU. It captures the ALU result and the EX-stage control bundle for the MEM stage, and honours stall and flush from the hazard unit. It turns the ALU overflow flag on ADD/SUB into a precise arithmetic-overflow exception: it kills the faulting instruction, records EPC and cause, and holds an exception request until the control unit acknowledges it.

## Interface
Parameters:
- OVF_CAUSE, 5'd12, cause code reported for arithmetic overflow.
- CNT_W, 8, width of the saturating overflow event counter.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  reset, active-low, asynchronous assert. One clock; reset is asynchronous and active-low.
- stall  in  1  hold all pipeline registers.
- flush  in  1  load a bubble; has priority over stall.
- ex_valid  in  1  EX slot holds a real instruction.
- ex_pc  in  32  PC of EX instruction.
- ex_alu_result  in  32  ALU result.
- ex_alu_overflow  in  1  ALU signed-overflow flag (already gated to ADD/SUB).
- ex_reg_write  in  1  writeback enable.
- ex_reg_write_addr  in  5  destination register.
- ex_mem_read  in  1  load.
- ex_mem_write  in  1  store.
- ex_mem_write_data  in  32  store data.
- exc_ack  in  1  control unit has taken the exception.
- mem_valid  out  1  registered ex_valid.
- mem_pc  out  32  registered PC.
- mem_alu_result  out  32  registered result / address.
- mem_reg_write  out  1  registered writeback enable.
- mem_reg_write_addr  out  5  registered destination.
- mem_mem_read  out  1  registered load.
- mem_mem_write  out  1  registered store.
- mem_mem_write_data  out  32  registered store data.
- exc_pending  out  1  exception request, level, held until ack.
- exc_epc  out  32  PC of faulting instruction.
- exc_cause  out  5  cause code.
- ovf_count  out  CNT_W  saturating count of overflow traps taken.

## Operation
- States: RUN, TRAP_WAIT. Reset state RUN.
- Bubble means mem_valid, mem_reg_write, mem_mem_read and mem_mem_write = 0, mem_reg_write_addr = 0, mem_pc/mem_alu_result/mem_mem_write_data = 0.
- RUN, per rising edge, in priority order:
  - flush=1: load bubble; ex_alu_overflow ignored.
  - stall=1: all pipeline regs, EPC, cause and counter hold; overflow not sampled.
  - ex_valid=1 and ex_alu_overflow=1: load bubble (faulting instruction killed, no writeback, no memory access). exc_epc<=ex_pc, exc_cause<=OVF_CAUSE, exc_pending<=1, ovf_count+=1 saturating at all-ones. Next state TRAP_WAIT.
  - otherwise: load all ex_* into mem_* (an ex_valid=0 slot loads as-is with controls forced 0).
- ex_alu_overflow with ex_valid=0 is ignored.
- TRAP_WAIT:
  - exc_pending=1.
  - Bubble loaded every edge regardless of stall/flush/inputs.
  - exc_epc and exc_cause hold.
  - exc_ack=1 on an edge: exc_pending<=0, next state RUN. The bubble is still loaded on that edge; the first real capture is the following edge.
- exc_ack in RUN: ignored.
- Only one exception outstanding; a second overflow cannot be sampled until RUN is re-entered.
- exc_epc/exc_cause retain the last trap's values after ack, until the next trap.

## Timing
- Latency: 1 cycle EX to MEM, no combinational path from any input to any output.
- exc_pending rises on the edge that captures the faulting instruction. It stays high at least 1 cycle and until the edge sampling exc_ack=1.
- Reset (async, rst_n=0): all outputs 0, ovf_count 0, state RUN, effective immediately without a clock. Deassertion takes effect at the next edge.
- Reset mid-TRAP_WAIT drops exc_pending immediately and discards EPC and cause.
- Simultaneous flush and stall in RUN: flush wins, bubble loaded.
- Simultaneous flush and overflow: no trap, counter unchanged.
- ovf_count at 2^CNT_W-1 stays there on further traps.

## Test plan
- Pass-through: ex_valid=1, ex_pc=0x0040_0010, result 0x1234_5678, reg_write=1, addr=5, no overflow -> next cycle mem_* match exactly, exc_pending=0.
- Stall/flush: capture value A, then 3 cycles stall=1 with changing inputs -> mem_* stay A. Then stall=1 with flush=1 -> mem_valid=0 and mem_reg_write=0 next cycle.
- Overflow trap: ADD 0x7FFF_FFFF+1 with ALU flag=1, ex_pc=0x0040_0020 -> next cycle mem_reg_write=0, mem_valid=0, exc_pending=1, exc_epc=0x0040_0020, exc_cause=12, ovf_count=1. Hold exc_ack=0 for 4 cycles -> pending stays 1 and mem_* stay bubble with valid inputs applied. Pulse exc_ack -> pending 0 next cycle; the next instruction is captured one cycle later.
- Masked overflows: overflow with ex_valid=0, overflow with flush=1, overflow with stall=1 -> no trap, ovf_count unchanged.
- Saturation: CNT_W=2, take 5 traps each acked -> ovf_count sequence 1, 2, 3, 3, 3.
- Async reset during TRAP_WAIT: drop rst_n between clock edges -> exc_pending, exc_epc and all mem_* go 0 immediately. After release, a normal instruction passes through.
